// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB3 register bank with ID, CTRL (programmable wait states) and scratch registers
// Ports:
//   hclk, hreset      clock and synchronous active-high reset
//   psel, penable     APB select and access-phase strobes
//   pwrite, paddr     transfer direction and byte address
//   pwdata            write data
//   prdata            registered read data, non-zero only on a legal read completion
//   pready, pslverr   registered completion pulse and error flag
module apb_slave_regbank #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [DATA_WIDTH-1:0] ID = DATA_WIDTH'(32'hA5B2_0001);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d, ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] scr_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] scr_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0] ra;
  logic                  rw, rlegal, rerr;
  logic [IW-1:0]         ridx;
  logic [DATA_WIDTH-1:0] rval, rresp;
  // The response is computed from the live bus in the setup cycle (zero-wait
  // case) and from the latched transfer once in ACCESS.
  always_comb begin
    ra     = state_q == IDLE ? paddr : addr_q;
    rw     = state_q == IDLE ? pwrite : write_q;
    ridx   = ra[IW+1:2];
    rlegal = ra[1:0] == 2'b00 && (ra >> (IW + 2)) == '0;
    rerr   = ~rlegal | (rw & ridx == '0);
    rval   = ridx == '0 ? ID : ridx == IW'(1) ? {{(DATA_WIDTH-4){1'b0}}, ctrl_q} : scr_q[ridx];
    rresp  = rw | rerr ? '0 : rval;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    ctrl_d    = ctrl_q;
    scr_d     = scr_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    if (state_q == IDLE) begin
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      if (psel & ~penable) begin
        state_d   = ACCESS;
        addr_d    = paddr;
        write_d   = pwrite;
        wdata_d   = pwdata;
        cnt_d     = ctrl_q;
        pready_d  = ctrl_q == 4'd0;
        prdata_d  = ctrl_q == 4'd0 ? rresp : '0;
        pslverr_d = ctrl_q == 4'd0 & rerr;
      end
    end else if (~psel) begin
      state_d   = IDLE;
      cnt_d     = 4'd0;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
    end else if (pready_q) begin
      if (penable) begin
        if (write_q & ~rerr) begin
          if (ridx == IW'(1)) ctrl_d = wdata_q[3:0];
          else scr_d[ridx] = wdata_q;
        end
        state_d   = IDLE;
        cnt_d     = 4'd0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    end else if (penable) begin
      // penable low while waiting freezes the counter
      cnt_d     = cnt_q - 4'd1;
      pready_d  = cnt_q == 4'd1;
      prdata_d  = cnt_q == 4'd1 ? rresp : '0;
      pslverr_d = cnt_q == 4'd1 & rerr;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      ctrl_q    <= 4'(WAIT_CYCLES);
      scr_q     <= '{default: '0};
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      ctrl_q    <= ctrl_d;
      scr_q     <= scr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end
  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: scoreboard bench for apb_slave_regbank
module tb_apb_slave_regbank;
  localparam int WC = 0;
  logic        hclk, hreset, psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          w;
  } exp_t;
  exp_t sb[$];
  exp_t ex;
  int checks = 0, errors = 0, issued = 0, pulses = 0, waits = 0, w_model = WC;
  logic [31:0] dat [5] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
  apb_slave_regbank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(WC)) dut (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  always @(negedge hclk) begin
    if (hreset) waits = 0;
    else if (pready) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready prdata=%h pslverr=%b", prdata, pslverr);
      end else begin
        ex = sb.pop_front();
        if (prdata !== ex.d || pslverr !== ex.e || waits != ex.w) begin
          errors++;
          $display("FAIL resp got data=%h err=%b waits=%0d want data=%h err=%b waits=%0d",
                   prdata, pslverr, waits, ex.d, ex.e, ex.w);
        end
      end
      waits = 0;
    end else if (psel && penable) waits++;
  end
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee);
    int n = 0;
    sb.push_back('{ed, ee, w_model});
    issued++;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    while (!pready && n < 40) begin
      tick();
      n++;
    end
    if (!pready) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h pready=%b want 1", a, pready);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    tick();
    psel = 1'b0; penable = 1'b0;
    if (wr && a == 32'h4) w_model = int'(d[3:0]);
  endtask
  initial begin
    hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) begin
      @(negedge hclk);
      checks++;
      if (pready !== 1'b0 || prdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs pready=%b prdata=%h want 0 0", pready, prdata);
      end
    end
    tick();
    hreset = 1'b0;
    apb(0, 32'h00, 0, 32'hA5B2_0001, 0);
    apb(0, 32'h04, 0, 32'(WC), 0);
    apb(1, 32'h08, 32'hDEAD_BEEF, 0, 0);
    apb(0, 32'h08, 0, 32'hDEAD_BEEF, 0);
    apb(1, 32'h04, 32'hABCD_0013, 0, 0);
    apb(0, 32'h08, 0, 32'hDEAD_BEEF, 0);
    apb(0, 32'h04, 0, 32'h3, 0);
    apb(1, 32'h00, 32'h1234, 0, 1);
    apb(0, 32'h00, 0, 32'hA5B2_0001, 0);
    apb(0, 32'h40, 0, 0, 1);
    apb(0, 32'h0A, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = 32'($urandom_range(0, 3));
      apb(1, 32'h04, w, 0, 0);
      repeat ($urandom_range(0, 3)) tick();
      if (i < 5) apb(1, 32'h08 + 32'(4 * i), dat[i], 0, 0);
      else apb(0, 32'h08 + 32'(4 * (i - 5)), 0, dat[i-5], 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    apb(1, 32'h04, 32'h3, 0, 0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h5555_AAAA;
    tick();
    penable = 1'b1;
    tick();
    hreset = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    hreset = 1'b0;
    w_model = WC;
    apb(0, 32'h0C, 0, 0, 0);
    apb(0, 32'h04, 0, 32'(WC), 0);
    repeat (3) tick();
    checks++;
    if (sb.size() != 0 || pulses != issued) begin
      errors++;
      $display("FAIL pulse_count pulses=%0d pending=%0d want pulses=%0d pending=0", pulses, sb.size(), issued);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
